// File: rtl/sample_scheduler.sv
// Sensor sweep scheduler: per channel, hold the shared counter in reset, open a
// measurement window, wait for the synchronizer to settle, then strobe an SRAM write.
module sample_scheduler #(
    parameter int NUM_CH  = 5,
    parameter int RST_CYC = 4
) (
    input  logic        clk_sample,
    input  logic        rstn,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        cont_i,
    input  logic [15:0] win_len_i,
    input  logic [7:0]  settle_len_i,
    output logic        cnt_rstn_o,
    output logic        sample_o,
    output logic [4:0]  wr_addr_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] round_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CRST   = 3'd1,
        WIN    = 3'd2,
        SETTLE = 3'd3,
        WRITE  = 3'd4
    } state_t;

    localparam logic [4:0]  LAST_CH   = 5'(NUM_CH - 1);
    localparam logic [15:0] CRST_LOAD = 16'(RST_CYC - 1);

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [4:0]  ch_r, ch_s;
    logic        cont_r, cont_s;
    logic [15:0] win_r, win_s;
    logic [7:0]  settle_r, settle_s;
    logic [15:0] round_s;
    logic        done_s;
    logic        cnt_rstn_s;
    logic        sample_s;
    logic        busy_s;

    // Next-state logic; phase counter is loaded with (length-1) and counts down to zero.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        ch_s     = ch_r;
        cont_s   = cont_r;
        win_s    = win_r;
        settle_s = settle_r;
        round_s  = round_o;
        done_s   = 1'b0;
        if (abort_i) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        cont_s   = cont_i;
                        win_s    = win_len_i;
                        settle_s = settle_len_i;
                        ch_s     = 5'd0;
                        cnt_s    = CRST_LOAD;
                        state_s  = CRST;
                    end else begin
                        state_s = IDLE;
                    end
                end
                CRST: begin
                    if (cnt_r == 16'd0) begin
                        // A zero-length window still opens for one cycle.
                        cnt_s   = (win_r == 16'd0) ? 16'd0 : (win_r - 16'd1);
                        state_s = WIN;
                    end else begin
                        cnt_s = cnt_r - 16'd1;
                    end
                end
                WIN: begin
                    if (cnt_r == 16'd0) begin
                        cnt_s   = {8'd0, settle_r} - 16'd1;
                        state_s = (settle_r == 8'd0) ? WRITE : SETTLE;
                    end else begin
                        cnt_s = cnt_r - 16'd1;
                    end
                end
                SETTLE: begin
                    if (cnt_r == 16'd0) begin
                        state_s = WRITE;
                    end else begin
                        cnt_s = cnt_r - 16'd1;
                    end
                end
                WRITE: begin
                    cnt_s = CRST_LOAD;
                    if (ch_r == LAST_CH) begin
                        round_s = round_o + 16'd1;
                        if (cont_r) begin
                            ch_s    = 5'd0;
                            state_s = CRST;
                        end else begin
                            done_s  = 1'b1;
                            state_s = IDLE;
                        end
                    end else begin
                        ch_s    = ch_r + 5'd1;
                        state_s = CRST;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
        cnt_rstn_s = (state_s == WIN) || (state_s == SETTLE) || (state_s == WRITE);
        sample_s   = (state_s == WRITE);
        busy_s     = (state_s != IDLE);
    end

    // State, phase counter, channel and latched sweep parameters.
    always_ff @(posedge clk_sample or negedge rstn) begin
        if (!rstn) begin
            state_r  <= IDLE;
            cnt_r    <= 16'd0;
            ch_r     <= 5'd0;
            cont_r   <= 1'b0;
            win_r    <= 16'd0;
            settle_r <= 8'd0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            ch_r     <= ch_s;
            cont_r   <= cont_s;
            win_r    <= win_s;
            settle_r <= settle_s;
        end
    end

    // Outputs registered from next-state values so they line up with the state register.
    always_ff @(posedge clk_sample or negedge rstn) begin
        if (!rstn) begin
            cnt_rstn_o <= 1'b0;
            sample_o   <= 1'b0;
            wr_addr_o  <= 5'd0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            round_o    <= 16'd0;
        end else begin
            cnt_rstn_o <= cnt_rstn_s;
            sample_o   <= sample_s;
            wr_addr_o  <= ch_s;
            busy_o     <= busy_s;
            done_o     <= done_s;
            round_o    <= round_s;
        end
    end

endmodule
